// File: rtl/mips_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
// Arbitration policy macro: MIPS_ARB_ROUND_ROBIN_EN (defined = round-robin,
// undefined = fixed priority with master 0 highest).
package mips_bus_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Default bus geometry
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Master indices as carried on the 1-bit pointer / winner signals
    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    // One-hot grant vector belonging to a state (bit0 = master 0)
    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ST_OWN0: g = 2'b01;
            ST_OWN1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Combinational winner selection between the two bus masters.
// Policy macro: MIPS_ARB_ROUND_ROBIN_EN (defined = preferred master wins ties,
// undefined = master 0 always wins ties and the prefer input is ignored).
module mips_bus_arb_pick
    import mips_bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prefer,
    output logic valid,
    output logic winner
);

    // Pick a winner from the request bits under the configured policy
    always_comb begin
        valid  = req0 | req1;
        winner = M0_IDX;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            winner = prefer;
        end else if (req1) begin
            winner = M1_IDX;
        end else begin
            winner = M0_IDX;
        end
`else
        if (req0) begin
            winner = M0_IDX;
        end else if (req1) begin
            winner = M1_IDX;
        end else begin
            winner = M0_IDX;
        end
`endif
    end

`ifndef MIPS_ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the preference input
    logic unused_prefer_s;
    assign unused_prefer_s = prefer;
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter in front of a single memory slave. The owner is held in a
// registered state; the owner's command is forwarded combinationally and the
// other master is stalled via waitrequest. Ownership only moves at a completed
// transfer (owner requesting with slave waitrequest low) or via IDLE.
// Policy macro: MIPS_ARB_ROUND_ROBIN_EN (see mips_bus_arb_pick).
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    output logic [1:0]            grant
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       ptr_q, ptr_d;

    logic req0_s, req1_s;
    logic own_req_s, own_idx_s, complete_s;
    logic prefer_s, pick_valid_s, pick_winner_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Owner's request, completion and the preference fed to the picker.
    // While owning, the preference points at the other master so that a
    // round-robin completion hands over whenever the other one is waiting.
    always_comb begin
        own_req_s = 1'b0;
        own_idx_s = M0_IDX;
        prefer_s  = ptr_q;
        case (state_q)
            ST_OWN0: begin
                own_req_s = req0_s;
                own_idx_s = M0_IDX;
                prefer_s  = M1_IDX;
            end
            ST_OWN1: begin
                own_req_s = req1_s;
                own_idx_s = M1_IDX;
                prefer_s  = M0_IDX;
            end
            default: begin
                own_req_s = 1'b0;
                own_idx_s = M0_IDX;
                prefer_s  = ptr_q;
            end
        endcase
        complete_s = own_req_s & ~s_waitrequest;
    end

    mips_bus_arb_pick u_pick (
        .req0   (req0_s),
        .req1   (req1_s),
        .prefer (prefer_s),
        .valid  (pick_valid_s),
        .winner (pick_winner_s)
    );

    // Next-state, next-grant and round-robin pointer update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = (pick_winner_s == M1_IDX) ? ST_OWN1 : ST_OWN0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req_s) begin
                    state_d = ST_IDLE;
                end else if (complete_s) begin
                    // The owner is requesting, so the picker always has a winner
                    state_d = (pick_winner_s == M1_IDX) ? ST_OWN1 : ST_OWN0;
                    ptr_d   = ~own_idx_s;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        grant_d = grant_of(state_d);
    end

    // State, grant and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            ptr_q   <= M0_IDX;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Forward the owner's command to the slave and stall everyone else.
    // An owner that has dropped its request forwards nothing.
    always_comb begin
        s_address      = {ADDR_W{1'b0}};
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = {DATA_W{1'b0}};
        s_byteenable   = {BE_W{1'b0}};
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            ST_OWN0: begin
                m0_waitrequest = s_waitrequest;
                if (req0_s) begin
                    s_address    = m0_address;
                    s_read       = m0_read;
                    s_write      = m0_write;
                    s_writedata  = m0_writedata;
                    s_byteenable = m0_byteenable;
                end else begin
                    s_read  = 1'b0;
                    s_write = 1'b0;
                end
            end
            ST_OWN1: begin
                m1_waitrequest = s_waitrequest;
                if (req1_s) begin
                    s_address    = m1_address;
                    s_read       = m1_read;
                    s_write      = m1_write;
                    s_writedata  = m1_writedata;
                    s_byteenable = m1_byteenable;
                end else begin
                    s_read  = 1'b0;
                    s_write = 1'b0;
                end
            end
            default: begin
                m0_waitrequest = 1'b1;
                m1_waitrequest = 1'b1;
            end
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign grant       = grant_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios followed by
// randomized protocol-legal masters, all checked against an ownership model.
module tb_mips_bus_arbiter;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic [1:0]  grant;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master command registers (index = master number)
    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic        wc [2];

    // Reference model: owner -1 = nobody, otherwise master index
    int own;
    int ptr;
    int n_assert;
    int n_fail;
    int stall0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        m0_read = rd[0]; m0_write = wr[0]; m0_address = ad[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
        m1_read = rd[1]; m1_write = wr[1]; m1_address = ad[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
    endtask

    // Compare every output against what the current owner implies
    task automatic check_cycle();
        logic [1:0]  eg;
        logic        er, ew, ew0, ew1;
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        er = 1'b0; ew = 1'b0; ea = 32'h0; ed = 32'h0; eb = 4'h0;
        ew0 = 1'b1; ew1 = 1'b1;
        if (own >= 0) begin
            if (own == 0) ew0 = s_waitrequest;
            else          ew1 = s_waitrequest;
            if (rd[own] | wr[own]) begin
                er = rd[own]; ew = wr[own]; ea = ad[own]; ed = wd[own]; eb = be[own];
            end
        end
        chk("grant",    64'(grant),          64'(eg));
        chk("s_read",   64'(s_read),         64'(er));
        chk("s_write",  64'(s_write),        64'(ew));
        chk("s_addr",   64'(s_address),      64'(ea));
        chk("s_wdata",  64'(s_writedata),    64'(ed));
        chk("s_be",     64'(s_byteenable),   64'(eb));
        chk("m0_wait",  64'(m0_waitrequest), 64'(ew0));
        chk("m1_wait",  64'(m1_waitrequest), 64'(ew1));
        chk("m0_rdata", 64'(m0_readdata),    64'(s_readdata));
        chk("m1_rdata", 64'(m1_readdata),    64'(s_readdata));
    endtask

    // Advance the ownership model across one clock edge
    task automatic model_step();
        bit r [2];
        int o;
        r[0] = rd[0] | wr[0];
        r[1] = rd[1] | wr[1];
        if (reset) begin
            own = -1; ptr = 0;
        end else if (own < 0) begin
            if (r[0] && r[1]) own = RR ? ptr : 0;
            else if (r[0])    own = 0;
            else if (r[1])    own = 1;
        end else begin
            o = 1 - own;
            if (!r[own]) begin
                own = -1;
            end else if (!s_waitrequest) begin
                if (RR) begin
                    ptr = o;
                    if (r[o]) own = o;
                end else if (own == 1 && r[0]) begin
                    own = 0;
                end
            end
        end
    endtask

    // One bus cycle: check mid-cycle, update model, return just after the edge
    task automatic cycle();
        @(negedge clk);
        check_cycle();
        wc[0] = m0_waitrequest;
        wc[1] = m1_waitrequest;
        if ((rd[0] | wr[0]) && wc[0]) stall0++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        for (int m = 0; m < 2; m++) begin
            rd[m] = 1'b0; wr[m] = 1'b0; ad[m] = 32'h0; wd[m] = 32'h0; be[m] = 4'h0;
        end
        apply();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; stall0 = 0;
        own = -1; ptr = 0;
        reset = 1'b1;
        s_waitrequest = 1'b0;
        s_readdata = 32'h0;
        idle_masters();
        wc[0] = 1'b1; wc[1] = 1'b1;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        cycle();
        chk("rst_grant",  64'(grant),          64'(2'b00));
        chk("rst_s_read", 64'(s_read),         64'(1'b0));
        chk("rst_s_wr",   64'(s_write),        64'(1'b0));
        chk("rst_m0_wr",  64'(m0_waitrequest), 64'(1'b1));
        chk("rst_m1_wr",  64'(m1_waitrequest), 64'(1'b1));
        reset = 1'b0;

        // Single m0 read with two slave stall cycles
        rd[0] = 1'b1; ad[0] = 32'hBFC00004; be[0] = 4'hF; apply();
        s_waitrequest = 1'b1;
        stall0 = 0;
        cycle();
        chk("t1_grant", 64'(grant), 64'(2'b01));
        cycle();
        cycle();
        s_waitrequest = 1'b0; s_readdata = 32'h0000F100;
        cycle();
        chk("t1_stalls", 64'(stall0),      64'(3));
        chk("t1_rdata",  64'(m0_readdata), 64'(32'h0000F100));

        // Release: owner drops request, strobes low, then IDLE
        rd[0] = 1'b0; apply();
        #1;
        chk("rel_grant_own", 64'(grant),  64'(2'b01));
        chk("rel_s_read",    64'(s_read), 64'(1'b0));
        cycle();
        chk("rel_grant_idle", 64'(grant), 64'(2'b00));

        // Simultaneous requests from IDLE
        pulse_reset();
        rd[0] = 1'b1; ad[0] = 32'h00001000; be[0] = 4'hF;
        rd[1] = 1'b1; ad[1] = 32'h00002000; be[1] = 4'h3; apply();
        s_waitrequest = 1'b0;
        cycle();
        chk("t2_first", 64'(grant), 64'(2'b01));
        cycle();
        chk("t2_after", 64'(grant), RR ? 64'(2'b10) : 64'(2'b01));
        cycle();
        chk("t2_third", 64'(grant), RR ? 64'(2'b01) : 64'(2'b01));
        idle_masters();
        cycle();
        cycle();

        // No preemption while the slave stalls an m1 write
        pulse_reset();
        wr[1] = 1'b1; ad[1] = 32'h00000100; wd[1] = 32'hE0000000; be[1] = 4'hF; apply();
        s_waitrequest = 1'b1;
        cycle();
        chk("t3_grant1", 64'(grant), 64'(2'b10));
        rd[0] = 1'b1; ad[0] = 32'h00000200; be[0] = 4'hF; apply();
        cycle();
        cycle();
        chk("t3_wdata",  64'(s_writedata), 64'(32'hE0000000));
        chk("t3_grant2", 64'(grant),       64'(2'b10));
        s_waitrequest = 1'b0;
        cycle();
        chk("t3_handover", 64'(grant), 64'(2'b01));
        wr[1] = 1'b0; apply();
        cycle();
        idle_masters();
        cycle();
        cycle();

        // Reset pulsed while OWN1 is stalled
        wr[1] = 1'b1; ad[1] = 32'h00000300; wd[1] = 32'h12345678; be[1] = 4'hF; apply();
        s_waitrequest = 1'b1;
        cycle();
        cycle();
        chk("t4_own1", 64'(grant), 64'(2'b10));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t4_s_write", 64'(s_write), 64'(1'b0));
        chk("t4_grant",   64'(grant),   64'(2'b00));
        cycle();
        idle_masters();
        s_waitrequest = 1'b0;
        cycle();
        cycle();

        // Randomized protocol-legal masters and slave
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(rd[m] | wr[m]) || !wc[m]) begin
                    if ($urandom_range(0, 99) < 55) begin
                        rd[m] = 1'($urandom_range(0, 1));
                        wr[m] = rd[m] ? ($urandom_range(0, 7) == 0) : 1'b1;
                        ad[m] = $urandom;
                        wd[m] = $urandom;
                        be[m] = 4'($urandom_range(0, 15));
                    end else begin
                        rd[m] = 1'b0; wr[m] = 1'b0;
                    end
                end
            end
            apply();
            s_waitrequest = ($urandom_range(0, 99) < 45);
            s_readdata = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter that shares the single memory bus (address/read/write/waitrequest/readdata/writedata/byteenable) between the `mips_cpu_bus` core (master 0) and a secondary requester such as a RAM loader or DMA engine (master 1). It sits between the masters and the memory slave. It holds a registered grant and forwards the granted master's command to the slave. Non-granted masters are stalled through `waitrequest`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byteenable width is `DATA_W/8`.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_address` / `m1_address`  in  ADDR_W  master byte address.
- `m0_read` / `m1_read`  in  1  read request.
- `m0_write` / `m1_write`  in  1  write request.
- `m0_writedata` / `m1_writedata`  in  DATA_W  write data.
- `m0_byteenable` / `m1_byteenable`  in  DATA_W/8  byte lanes.
- `m0_waitrequest` / `m1_waitrequest`  out  1  stall to master.
- `m0_readdata` / `m1_readdata`  out  DATA_W  read data.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`  out  (as above)  command to slave.
- `s_waitrequest`  in  1  slave stall.
- `s_readdata`  in  DATA_W  slave read data.
- `grant`  out  2  one-hot current owner: bit0 = master 0, bit1 = master 1; 0 = idle.

## Operation
- A master requests when `read | write` is 1. It must hold all command signals stable while its `waitrequest` is 1.
- State machine states: IDLE, OWN0, OWN1.
- IDLE:
  - With no requests, stay in IDLE.
  - With one request, go to the OWN state of that master.
  - With both requesting, the winner is chosen by policy (see Configuration).
- OWNx, command path: `s_*` equals master x's signals. `mx_waitrequest = s_waitrequest`.
- OWNx, completion: a transfer completes in a cycle where master x requests and `s_waitrequest = 0`.
- OWNx, next state after a completion:
  - If the other master is requesting and policy allows handover, go to OWN_other directly, with no IDLE bubble.
  - Otherwise stay in OWNx.
- OWNx, release: if master x has no request in a cycle, go to IDLE. Nothing is forwarded in that cycle.
- Non-granted master: `waitrequest = 1`, regardless of whether it is requesting.
- `m0_readdata` and `m1_readdata` both carry `s_readdata` unconditionally. Only the granted master samples it.
- Ownership never changes while `s_waitrequest = 1`. An in-flight transfer is never split or preempted.
- In IDLE, `s_read`, `s_write`, `s_address`, `s_writedata` and `s_byteenable` are all 0.
- Read and write asserted together are forwarded unchanged. No checking is done.

## Timing
- Reset values: state IDLE, `grant = 0`, all `s_*` outputs 0, `m0_waitrequest = m1_waitrequest = 1`, round-robin pointer = master 0 next.
- Arbitration latency:
  - A request first seen in IDLE in cycle N is granted in cycle N+1.
  - The slave sees the command in cycle N+1.
  - The earliest completion is cycle N+1.
- Handover at completion: the new owner's command reaches the slave in the very next cycle.
- Reset mid-transfer: in the cycle after the reset edge the slave strobes are 0. The transfer is abandoned and no retry is made.
- Output paths: `s_*` and `waitrequest` are combinational from the registered state plus the inputs. `grant` is registered.

## Configuration
- `MIPS_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin.
  - A 1-bit pointer names the master preferred next. It flips to the other master on every completed transfer.
  - The preferred master wins simultaneous requests in IDLE.
  - At a completion, if the other master is requesting, handover to it is forced.
- `MIPS_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, master 0 highest.
  - Master 0 wins all ties.
  - Master 0 takes over from master 1 at master 1's next completion.
  - Master 1 never takes over from master 0 while master 0 keeps requesting.

## Structure
- Shared package `mips_bus_pkg`: state enum (IDLE/OWN0/OWN1), `ADDR_W`/`DATA_W` default constants, and master index constants.
- One sub-module, `mips_bus_arb_pick`: combinational winner selection from the two request bits, pointer and policy. It is instantiated once; the FSM and muxing stay in the top.

## Test plan
- Reset: hold `reset` for 2 cycles -> `grant = 0`, `s_read = s_write = 0`, both `waitrequest = 1`.
- Single master 0 read of 0xBFC00004, slave `waitrequest` held 1 for 2 cycles then 0 with `s_readdata = 0x0000F100` -> `grant = 01` one cycle after the request; `m0` stalls 3 cycles and completes with readdata 0x0000F100; `m1_waitrequest = 1` throughout.
- Simultaneous requests from IDLE, both modes:
  - Round-robin: m0 granted first; after m0's completion `grant = 10` in the next cycle with no IDLE.
  - Fixed priority: same first grant; m0 keeps the bus while it continues requesting.
- No preemption during a stall: m1 write of 0xE0000000 in progress with `s_waitrequest = 1`, then m0 requests -> `s_writedata` stays 0xE0000000 until completion; a handover occurs only at the completion edge.
- Release: the owner drops its request -> the next state is IDLE and the slave strobes are 0 that cycle.
- Reset mid-transfer: `reset` pulsed while OWN1 is stalled -> the next cycle is IDLE with `s_write = 0` and `grant = 0`.
